// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the five-stage pipeline sequencer:
//   - fetch-FSM state encodings (IDLE/WAIT/HOLD/DROP)
//   - stage indices used to address the per-stage control vectors
// No ports (package).
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Fetch FSM states
    localparam logic [1:0] FS_IDLE = 2'd0;  // issue a fetch this cycle
    localparam logic [1:0] FS_WAIT = 2'd1;  // fetch outstanding
    localparam logic [1:0] FS_HOLD = 2'd2;  // instruction returned, ID full
    localparam logic [1:0] FS_DROP = 2'd3;  // outstanding fetch is dead, eat its ack

    // Stage indices; IF acts as the "previous stage" of ID
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_stage_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stage_ctrl
// One pipeline stage's valid flop and allow-in/ready-go handshake.
// Ports:
//   clk, rst            core clock, async active-high reset
//   valid_prev_i        previous stage holds a live instruction
//   ready_go_prev_i     previous stage may hand its instruction on
//   ready_go_i          this stage may hand its instruction on
//   allowin_next_i      next stage can accept this cycle
//   valid_o             this stage holds a live instruction
//   allowin_o           this stage can accept this cycle
//   we_o                load enable for this stage's input pipeline register
// -----------------------------------------------------------------------------
module pipe_stage_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic valid_prev_i,
    input  logic ready_go_prev_i,
    input  logic ready_go_i,
    input  logic allowin_next_i,
    output logic valid_o,
    output logic allowin_o,
    output logic we_o
);

    logic valid_q;
    logic valid_d;

    assign allowin_o = !valid_q || (ready_go_i && allowin_next_i);
    assign we_o      = allowin_o && valid_prev_i && ready_go_prev_i;
    // An accepting stage takes a bubble if the previous one can't hand over
    assign valid_d   = allowin_o ? (valid_prev_i && ready_go_prev_i) : valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer for the five-stage (IF/ID/EX/MEM/WB) core: owns the stage
// valid bits, the allow-in chain, the fetch FSM and the pre-IF PC select.
// Optional feature macro: PIPE_CTRL_PERF_EN (stall/flush performance counters;
// when undefined the counter outputs are tied to 0 and no counter flops exist).
// Ports:
//   clk, rst                      core clock, async active-high reset
//   inst_ack_i                    instruction SRAM returns the outstanding fetch
//   id_load_use_i                 ID operand depends on the load in EX
//   id_jmp_i                      ID jump taken
//   mem_req_i, mem_ack_i          MEM data-SRAM access / completion
//   inst_req_o                    issue a fetch at the pre-IF PC
//   pc_we_o, pc_sel_jmp_o         pre-IF PC load enable / select jump target
//   if_id_we_o .. mem_wb_we_o     pipeline register load enables
//   id_valid_o .. wb_valid_o      stage holds a live instruction
//   stall_cnt_o, flush_cnt_o      performance counters (CNT_W bits)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_ack_i,
    input  logic             id_load_use_i,
    input  logic             id_jmp_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             inst_req_o,
    output logic             pc_we_o,
    output logic             pc_sel_jmp_o,
    output logic             if_id_we_o,
    output logic             id_ex_we_o,
    output logic             ex_mem_we_o,
    output logic             mem_wb_we_o,
    output logic             id_valid_o,
    output logic             ex_valid_o,
    output logic             mem_valid_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [STG_WB:STG_IF] vld;   // vld[STG_IF]: fetched instruction ready for ID
    logic [STG_WB:STG_IF] rg;    // ready_go per stage
    logic [STG_WB:STG_ID] alw;   // allowin per stage
    logic [STG_WB:STG_ID] we;    // register load enable into each stage

    logic [1:0] fs_q, fs_d;
    logic       jmp_fire;

    // ---------------- ready_go ----------------
    assign rg[STG_IF]  = 1'b1;
    assign rg[STG_ID]  = !id_load_use_i;
    assign rg[STG_EX]  = 1'b1;
    assign rg[STG_MEM] = !mem_req_i || mem_ack_i;
    assign rg[STG_WB]  = 1'b1;

    // Jump resolves in ID; load-use wins because it drops ID ready_go, and a
    // blocked EX defers the redirect until ID can actually move on.
    assign jmp_fire = vld[STG_ID] && rg[STG_ID] && id_jmp_i && alw[STG_EX];

    // The returning (or held) instruction is the wrong-path one when a jump fires
    assign vld[STG_IF] = ((fs_q == FS_WAIT && inst_ack_i) || fs_q == FS_HOLD) && !jmp_fire;

    // ---------------- stage chain ----------------
    for (genvar s = STG_ID; s <= STG_WB; s++) begin : g_stg
        logic alw_nx;
        if (s == STG_WB) begin : g_last
            assign alw_nx = 1'b1;
        end else begin : g_mid
            assign alw_nx = alw[s+1];
        end

        pipe_stage_ctrl u_stg (
            .clk            (clk),
            .rst            (rst),
            .valid_prev_i   (vld[s-1]),
            .ready_go_prev_i(rg[s-1]),
            .ready_go_i     (rg[s]),
            .allowin_next_i (alw_nx),
            .valid_o        (vld[s]),
            .allowin_o      (alw[s]),
            .we_o           (we[s])
        );
    end

    // ---------------- fetch FSM ----------------
    always_comb begin
        fs_d = fs_q;
        case (fs_q)
            // A jump in IDLE redirects the PC in the same cycle the
            // fall-through request goes out, so that fetch must be dropped.
            FS_IDLE: fs_d = jmp_fire ? FS_DROP : FS_WAIT;
            FS_WAIT: begin
                if (jmp_fire)        fs_d = inst_ack_i ? FS_IDLE : FS_DROP;
                else if (inst_ack_i) fs_d = alw[STG_ID] ? FS_IDLE : FS_HOLD;
            end
            FS_HOLD: if (jmp_fire || alw[STG_ID]) fs_d = FS_IDLE;
            FS_DROP: if (inst_ack_i) fs_d = FS_IDLE;
            default: fs_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fs_q <= FS_IDLE;
        else     fs_q <= fs_d;
    end

    // ---------------- outputs ----------------
    assign inst_req_o   = (fs_q == FS_IDLE) && !rst;
    assign pc_sel_jmp_o = jmp_fire;
    // PC advances when IF/ID accepts a fetch; never both in one cycle since
    // a firing jump squashes the IF/ID load.
    assign pc_we_o      = jmp_fire || we[STG_ID];

    assign if_id_we_o  = we[STG_ID];
    assign id_ex_we_o  = we[STG_EX];
    assign ex_mem_we_o = we[STG_MEM];
    assign mem_wb_we_o = we[STG_WB];

    assign id_valid_o  = vld[STG_ID];
    assign ex_valid_o  = vld[STG_EX];
    assign mem_valid_o = vld[STG_MEM];
    assign wb_valid_o  = vld[STG_WB];

    // ---------------- performance counters ----------------
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_ev;

    assign stall_ev    = (vld[STG_ID] && !rg[STG_ID]) || (vld[STG_MEM] && !rg[STG_MEM]);
    // Every firing jump kills exactly one fetch (held, returning or in flight)
    assign stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_ev};
    assign flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, jmp_fire};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed cycle table for pipe_ctrl. Each row drives one cycle of inputs and
// queues the hand-derived outputs for that cycle; a negedge monitor pops and
// compares the outputs and the performance counters.
// Output vector bit order: {req, pc_we, sel_jmp, ifid, idex, exmem, memwb,
//                           idv, exv, memv, wbv}
// Input vector bit order:  {rst, ack, load_use, jmp, mem_req, mem_ack}
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int CNT_W = 32;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ack = 1'b0, lu = 1'b0, jmp = 1'b0, mreq = 1'b0, mack = 1'b0;

    logic req, pc_we, sel, ifid, idex, exmem, memwb, idv, exv, memv, wbv;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_ack_i   (ack),
        .id_load_use_i(lu),
        .id_jmp_i     (jmp),
        .mem_req_i    (mreq),
        .mem_ack_i    (mack),
        .inst_req_o   (req),
        .pc_we_o      (pc_we),
        .pc_sel_jmp_o (sel),
        .if_id_we_o   (ifid),
        .id_ex_we_o   (idex),
        .ex_mem_we_o  (exmem),
        .mem_wb_we_o  (memwb),
        .id_valid_o   (idv),
        .ex_valid_o   (exv),
        .mem_valid_o  (memv),
        .wb_valid_o   (wbv),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [10:0]      o;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_run  = 0;
    int   n_fail = 0;
    int   row_n  = 0;

    logic [10:0] obs;
    assign obs = {req, pc_we, sel, ifid, idex, exmem, memwb, idv, exv, memv, wbv};

    // Drive one cycle's inputs just after the rising edge, queue the expectation
    task automatic row(input logic [5:0] in, input logic [10:0] o, input int sc, input int fc);
        exp_t e;
        @(posedge clk);
        #1;
        {rst, ack, lu, jmp, mreq, mack} = in;
        e.idx = row_n;
        e.o   = o;
        e.sc  = PERF ? CNT_W'(sc) : '0;
        e.fc  = PERF ? CNT_W'(fc) : '0;
        sb.push_back(e);
        row_n++;
    endtask

    // Monitor: outputs are settled at the falling edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            m_e = sb.pop_front();
            n_run++;
            if (obs !== m_e.o) begin
                n_fail++;
                $display("FAIL row%0d outs: got %b want %b", m_e.idx, obs, m_e.o);
            end
            n_run++;
            if (stall_cnt !== m_e.sc || flush_cnt !== m_e.fc) begin
                n_fail++;
                $display("FAIL row%0d cnt: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         m_e.idx, stall_cnt, flush_cnt, m_e.sc, m_e.fc);
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        // reset, ack during reset ignored
        row(6'b100000, 11'b000_0000_0000, 0, 0);
        row(6'b110000, 11'b000_0000_0000, 0, 0);
        // free-running fetch, 1-cycle ack
        row(6'b000000, 11'b100_0000_0000, 0, 0);  // c0 IDLE, first request
        row(6'b010000, 11'b010_1000_0000, 0, 0);  // c1 WAIT ack
        row(6'b000000, 11'b100_0100_1000, 0, 0);  // c2 id_valid first 1
        row(6'b010000, 11'b010_1010_0100, 0, 0);
        row(6'b000000, 11'b100_0101_1010, 0, 0);
        row(6'b010000, 11'b010_1010_0101, 0, 0);  // c5 wb_valid rises
        // load-use
        row(6'b001000, 11'b100_0001_1010, 0, 0);  // c6 id_ex_we 0
        row(6'b011000, 11'b000_0000_1001, 1, 0);  // c7 ex bubble, ack -> HOLD
        row(6'b000000, 11'b010_1100_1000, 2, 0);  // c8 HOLD loads IF/ID
        row(6'b000000, 11'b100_0110_1100, 2, 0);
        // MEM stall, ack 3 cycles late
        row(6'b010010, 11'b010_1000_0110, 2, 0);  // c10
        row(6'b000010, 11'b100_0000_1110, 3, 0);
        row(6'b010010, 11'b000_0000_1110, 4, 0);  // c12 ack with ID full -> HOLD
        row(6'b000011, 11'b010_1111_1110, 5, 0);  // c13 all resume
        // jump blocked by MEM stall, fires on mem ack while fetch WAITs
        row(6'b000110, 11'b100_0000_1111, 5, 0);  // c14 no redirect
        row(6'b000111, 11'b011_0111_1110, 6, 0);  // c15 jump fires, WAIT -> DROP
        row(6'b000000, 11'b000_0011_0111, 6, 1);  // c16 DROP
        row(6'b010000, 11'b000_0001_0011, 6, 1);  // c17 dropped ack
        row(6'b000000, 11'b100_0000_0001, 6, 1);  // c18 target requested
        row(6'b010000, 11'b010_1000_0000, 6, 1);
        // jump squashes a HOLD instruction
        row(6'b001000, 11'b100_0000_1000, 6, 1);  // c20 load-use
        row(6'b011000, 11'b000_0000_1000, 7, 1);  // c21 -> HOLD
        row(6'b000100, 11'b011_0100_1000, 8, 1);  // c22 jump, HOLD squashed
        row(6'b000000, 11'b100_0010_0100, 8, 2);
        row(6'b010000, 11'b010_1001_0010, 8, 2);
        row(6'b000000, 11'b100_0100_1001, 8, 2);
        row(6'b010000, 11'b010_1010_0100, 8, 2);
        // fill under MEM stall, reach HOLD, then reset
        row(6'b000010, 11'b100_0100_1010, 8, 2);  // c27
        row(6'b010010, 11'b010_1000_0110, 9, 2);
        row(6'b000010, 11'b100_0000_1110, 10, 2);
        row(6'b010010, 11'b000_0000_1110, 11, 2); // c30 -> HOLD
        row(6'b000010, 11'b000_0000_1110, 12, 2); // c31 in HOLD
        row(6'b110010, 11'b000_0000_0000, 0, 0);  // async reset mid-cycle
        row(6'b110000, 11'b000_0000_0000, 0, 0);
        row(6'b000000, 11'b100_0000_0000, 0, 0);  // IDLE again
        row(6'b010000, 11'b010_1000_0000, 0, 0);
        row(6'b000000, 11'b100_0100_1000, 0, 0);
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_run++;
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
